mult_unit: RTL

// - Iterative shift-add multiplier with architectural HI/LO registers for the MIPS EX stage.
// - Consumes start_mult and mult_sign from the control unit's main decoder: MULT is signed, MULTU is unsigned.
// - Feeds hi/lo to the EX result mux, which uses the decoder's out_select for MFHI/MFLO.
// - Tells the hazard unit to stall while a multiply is in flight.

---
 rtl/ctrl_pkg.sv | 13 +
 rtl/twos_negate.sv | 13 +
 rtl/mult_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the EX-stage multiplier.
package ctrl_pkg;

   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned MULT_CYCLES = DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } mult_state_t;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's complement negate: o_out = i_neg ? -i_in : i_in.
module twos_negate #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] i_in,
   input  logic         i_neg,
   output logic [W-1:0] o_out
);

   // Invert-and-increment only when negation is requested
   assign o_out = i_neg ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with architectural HI/LO for the EX stage.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the
// 2*WIDTH product is negated at the end when the operand signs differ.
module mult_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hilo_read,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW    = 2 * WIDTH;

   mult_state_t      r_state;
   logic             r_neg;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic             r_busy;

   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [PW-1:0]    w_mcand_ext;
   logic [PW-1:0]    w_addend;
   logic [PW-1:0]    w_prod;

   // Operand magnitudes; the most-negative value maps onto itself and is
   // then treated as an unsigned magnitude, which is exactly right
   twos_negate #(.W(WIDTH)) u_mag_a (
      .i_in  (op_a),
      .i_neg (mult_sign & op_a[WIDTH-1]),
      .o_out (w_mag_a)
   );

   twos_negate #(.W(WIDTH)) u_mag_b (
      .i_in  (op_b),
      .i_neg (mult_sign & op_b[WIDTH-1]),
      .o_out (w_mag_b)
   );

   // Sign fix-up of the full-width product
   twos_negate #(.W(PW)) u_fix (
      .i_in  (r_acc),
      .i_neg (r_neg),
      .o_out (w_prod)
   );

   // Partial product for the current step
   assign w_mcand_ext = PW'(r_mcand);
   assign w_addend    = w_mcand_ext << r_count;

   // Multiplier FSM, datapath and HI/LO commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_mult) begin
                  r_neg    <= mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  r_mcand  <= w_mag_a;
                  r_mplier <= w_mag_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + w_addend;
               end
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + CNT_W'(1);
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_hi    <= w_prod[PW-1:WIDTH];
               r_lo    <= w_prod[WIDTH-1:0];
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = r_busy;
   assign done = r_done;

   // Hold the pipeline only when the EX instruction depends on HI/LO
   assign stall = r_busy & (start_mult | hilo_read);

endmodule
